change_dispenser: RTL and testbench
===================================

# change_dispenser

Downstream neighbour of the money manager: takes the registered change amount and dispense strobe it produces and pays the change out as individual coins through a coin hopper. It uses a greedy ₹10/₹5/₹2/₹1 algorithm, with a per-coin valid/ack handshake to the hopper. It reports busy, done, remaining balance and hopper fault back to the vending controller.

## Interface
- CHANGE_W, 8, width of change amount and remaining balance
- ACK_TIMEOUT, 16, max cycles coin_valid may stay unacknowledged before fault
- INV_W, 8, per-denomination stock counter width (used only with inventory feature)
- INIT_STOCK, 50, stock value loaded at reset/refill (used only with inventory feature)

- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle strobe: change_in is valid, begin payout (driven from dispense)
- change_in  input  CHANGE_W  amount to pay out, ₹
- busy  output  1  payout in progress; start ignored while high
- coin_valid  output  1  request hopper to eject one coin of coin_denom
- coin_denom  output  2  00=₹1, 01=₹2, 10=₹5, 11=₹10
- coin_ack  input  1  hopper has ejected the requested coin
- remaining  output  CHANGE_W  balance still owed
- done  output  1  one-cycle pulse at end of payout
- fault  output  1  hopper ack timeout; held until next accepted start
- shortfall  output  1  payout ended with remaining>0 due to empty stock (inventory feature only)
- refill  input  1  reload all stock counters (inventory feature only)

## Operation
- Reset: state IDLE; busy, coin_valid, done, fault, shortfall = 0; coin_denom = 00; remaining = 0; stock counters = INIT_STOCK.
- States: IDLE, SELECT, ISSUE, DONE, FAULT.
- IDLE: on start, latch remaining = change_in, clear fault/shortfall. If change_in==0, go to DONE; else go to SELECT. Both paths set busy.
- SELECT: pick the largest denomination with value ≤ remaining (and stock>0 with the feature); register coin_denom, go to ISSUE. If no denomination qualifies, set shortfall and go to DONE.
- ISSUE: coin_valid=1 with coin_denom stable. On coin_ack: remaining -= value, decrement stock, drop coin_valid, zero the timeout counter. Then go to DONE if remaining==0, else go to SELECT.
- ISSUE timeout: if the counter reaches ACK_TIMEOUT, drop coin_valid, set fault, go to FAULT. remaining keeps the unpaid balance.
- DONE: done=1 for one cycle, busy=0 on exit, return to IDLE.
- FAULT: done pulse, then IDLE; fault stays high.
- Subtraction never underflows: the selected value is always ≤ remaining.
- start while busy: ignored. coin_ack outside ISSUE: ignored.
- reset_n low mid-payout: immediate return to reset values; the coin in flight is abandoned.

## Timing
- start sampled at edge N: busy=1 from N+1, coin_valid=1 from N+2.
- coin_ack sampled high at edge k while coin_valid: coin_valid=0 and remaining updated after k.
  - If more coins are owed, next coin_valid rises after k+1.
  - If remaining is 0, done=1 in cycle after k, busy=0 after k+1.
- coin_ack may be held low any number of cycles below ACK_TIMEOUT; coin_valid and coin_denom hold steady.
- change_in==0: done pulses in the cycle after N+1; no coin_valid.
- All outputs registered.

## Configuration
- COIN_INVENTORY_EN defined:
  - four INV_W stock counters, decremented on each ack;
  - empty denominations are skipped in SELECT;
  - shortfall is reported;
  - refill reloads all counters to INIT_STOCK, honoured only in IDLE.
- COIN_INVENTORY_EN undefined:
  - unlimited stock;
  - shortfall tied 0;
  - refill unused.

## Structure
- Shared package vend_pkg holds:
  - denomination code typedef and coin values (10/5/2/1);
  - state enum;
  - product price constants shared with the money manager.
- Sub-module coin_stock (the four counters, refill, empty flags) is instantiated only under COIN_INVENTORY_EN.

## Test plan
- start, change_in=65, immediate acks -> six ₹10 then one ₹5, remaining 65→5→0, single done pulse, fault=0.
- start, change_in=0 -> done pulse two cycles after start, no coin_valid.
- change_in=7, ack delayed 3 cycles per coin -> coin_valid/coin_denom held stable; coins ₹5, ₹2; done.
- change_in=20, coin_ack never asserted -> fault after ACK_TIMEOUT cycles, remaining=20, done pulse; next start clears fault.
- reset_n low during second coin of change_in=30 -> all outputs to reset values immediately; no done.
- COIN_INVENTORY_EN, INIT_STOCK=2, change_in=38 -> coins 10,10,5,5,2,2,1,1; shortfall=1, remaining=2; refill in IDLE restores payout.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared vending-machine types: coin denominations, dispenser states and product prices.
// Used by the money manager and the change dispenser.
package vend_pkg;

  localparam int unsigned NUM_DENOM = 4;

  typedef enum logic [1:0] {
    COIN_1  = 2'b00,
    COIN_2  = 2'b01,
    COIN_5  = 2'b10,
    COIN_10 = 2'b11
  } denom_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_ISSUE,
    ST_DONE,
    ST_FAULT
  } disp_state_e;

  // Product prices in rupees, shared with the money manager.
  localparam int unsigned PRICE_WATER = 10;
  localparam int unsigned PRICE_CANDY = 12;
  localparam int unsigned PRICE_CHIPS = 15;
  localparam int unsigned PRICE_SODA  = 25;

  function automatic logic [3:0] coin_value(denom_e d);
    unique case (d)
      COIN_1:  coin_value = 4'd1;
      COIN_2:  coin_value = 4'd2;
      COIN_5:  coin_value = 4'd5;
      default: coin_value = 4'd10;
    endcase
  endfunction

endpackage

// File: rtl/coin_stock.sv
// Per-denomination coin stock counters for the change dispenser.
// Counters load INIT_STOCK at reset or refill and decrement once per acknowledged coin.
module coin_stock
  import vend_pkg::*;
#(
  parameter int unsigned INV_W      = 8,
  parameter int unsigned INIT_STOCK = 50
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 refill_i,
  input  logic                 dec_i,
  input  denom_e               denom_i,
  output logic [NUM_DENOM-1:0] empty_o
);

  logic [INV_W-1:0] stock_q [NUM_DENOM];

  // NOTE: this small array is a bank of counters that must start full, so every
  // entry is reset; a real RAM would normally be left out of the reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_DENOM; i++) stock_q[i] <= INV_W'(INIT_STOCK);
    end else if (refill_i) begin
      for (int i = 0; i < NUM_DENOM; i++) stock_q[i] <= INV_W'(INIT_STOCK);
    end else if (dec_i && (stock_q[denom_i] != '0)) begin
      stock_q[denom_i] <= stock_q[denom_i] - INV_W'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_DENOM; i++) empty_o[i] = (stock_q[i] == '0);
  end

endmodule

// File: rtl/change_dispenser.sv
// Greedy Rs10/5/2/1 change payout with a per-coin valid/ack handshake to the coin hopper.
// Define COIN_INVENTORY_EN to track per-denomination stock and report shortfall.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned CHANGE_W    = 8,
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned INV_W       = 8,
  parameter int unsigned INIT_STOCK  = 50
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [CHANGE_W-1:0] change_in,
  output logic                busy,
  output logic                coin_valid,
  output logic [1:0]          coin_denom,
  input  logic                coin_ack,
  output logic [CHANGE_W-1:0] remaining,
  output logic                done,
  output logic                fault,
  output logic                shortfall,
  input  logic                refill
);

  localparam int unsigned TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  disp_state_e         state_q, state_d;
  logic [CHANGE_W-1:0] remaining_q, remaining_d;
  denom_e              denom_q, denom_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic                fault_q, fault_d;
  logic                short_q, short_d;
  logic [TMR_W-1:0]    timer_q, timer_d;

  logic [NUM_DENOM-1:0] stock_empty;
  logic                 stock_dec;
  logic                 sel_ok;
  denom_e               sel_denom;
  logic [CHANGE_W-1:0]  paid_left;

`ifdef COIN_INVENTORY_EN
  coin_stock #(
    .INV_W      (INV_W),
    .INIT_STOCK (INIT_STOCK)
  ) u_coin_stock (
    .clk      (clk),
    .reset_n  (reset_n),
    .refill_i (refill && (state_q == ST_IDLE)),
    .dec_i    (stock_dec),
    .denom_i  (denom_q),
    .empty_o  (stock_empty)
  );
  assign shortfall = short_q;
`else
  assign stock_empty = '0;
  assign shortfall   = 1'b0;
  wire unused_inv = &{1'b0, refill, stock_dec, short_q, INV_W[0], INIT_STOCK[0]};
`endif

  // Largest coin that fits the balance and is still in stock.
  always_comb begin
    sel_ok    = 1'b1;
    sel_denom = COIN_1;
    if (remaining_q >= CHANGE_W'(coin_value(COIN_10)) && !stock_empty[COIN_10]) begin
      sel_denom = COIN_10;
    end else if (remaining_q >= CHANGE_W'(coin_value(COIN_5)) && !stock_empty[COIN_5]) begin
      sel_denom = COIN_5;
    end else if (remaining_q >= CHANGE_W'(coin_value(COIN_2)) && !stock_empty[COIN_2]) begin
      sel_denom = COIN_2;
    end else if (remaining_q >= CHANGE_W'(coin_value(COIN_1)) && !stock_empty[COIN_1]) begin
      sel_denom = COIN_1;
    end else begin
      sel_ok = 1'b0;
    end
  end

  assign paid_left = remaining_q - CHANGE_W'(coin_value(denom_q));

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    denom_d     = denom_q;
    busy_d      = busy_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    fault_d     = fault_q;
    short_d     = short_q;
    timer_d     = timer_q;
    stock_dec   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          remaining_d = change_in;
          fault_d     = 1'b0;
          short_d     = 1'b0;
          busy_d      = 1'b1;
          state_d     = (change_in == '0) ? ST_DONE : ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (sel_ok) begin
          denom_d = sel_denom;
          valid_d = 1'b1;
          timer_d = '0;
          state_d = ST_ISSUE;
        end else begin
          short_d = 1'b1;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_ISSUE: begin
        if (coin_ack) begin
          remaining_d = paid_left;
          stock_dec   = 1'b1;
          valid_d     = 1'b0;
          timer_d     = '0;
          if (paid_left == '0) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_SELECT;
          end
        end else if (timer_q == TMR_W'(ACK_TIMEOUT - 1)) begin
          valid_d = 1'b0;
          fault_d = 1'b1;
          timer_d = '0;
          state_d = ST_FAULT;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      // The zero-change path arrives here without a pulse; coin paths already pulsed on entry.
      ST_DONE: begin
        done_d  = !done_q;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      ST_FAULT: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      denom_q     <= COIN_1;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      short_q     <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      denom_q     <= denom_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      short_q     <= short_d;
      timer_q     <= timer_d;
    end
  end

  assign busy       = busy_q;
  assign coin_valid = valid_q;
  assign coin_denom = denom_q;
  assign remaining  = remaining_q;
  assign done       = done_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: expected coins are planned by a greedy model
// when a payout starts and popped as the hopper acknowledges each coin.
module tb_change_dispenser;

  localparam int CW = 8;
  localparam int TO = 16;
  localparam int IW = 8;
  localparam int IS = 2;
`ifdef COIN_INVENTORY_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] change_in = '0;
  logic          coin_ack = 1'b0;
  logic          refill = 1'b0;
  logic          busy, coin_valid, done, fault, shortfall;
  logic [1:0]    coin_denom;
  logic [CW-1:0] remaining;

  always #5 clk = ~clk;

  change_dispenser #(
    .CHANGE_W    (CW),
    .ACK_TIMEOUT (TO),
    .INV_W       (IW),
    .INIT_STOCK  (IS)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .change_in  (change_in),
    .busy       (busy),
    .coin_valid (coin_valid),
    .coin_denom (coin_denom),
    .coin_ack   (coin_ack),
    .remaining  (remaining),
    .done       (done),
    .fault      (fault),
    .shortfall  (shortfall),
    .refill     (refill)
  );

  int         n_checks = 0;
  int         n_pass = 0;
  logic [1:0] exp_q[$];
  int         model_stock[4];
  int         exp_coins;
  int         exp_rem;

  function automatic int value_of(logic [1:0] d);
    case (d)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 5;
      default: return 10;
    endcase
  endfunction

  task automatic plan_payout(input int amt);
    int rem = amt;
    int st[4] = model_stock;
    bit found = 1'b1;
    exp_q.delete();
    exp_coins = 0;
    while (rem > 0 && found) begin
      found = 1'b0;
      for (int d = 3; d >= 0; d--) begin
        if (!found && value_of(2'(d)) <= rem && (!INV_EN || st[d] > 0)) begin
          found = 1'b1;
          exp_q.push_back(2'(d));
          rem -= value_of(2'(d));
          st[d]--;
          exp_coins++;
        end
      end
    end
    exp_rem = rem;
  endtask

  task automatic drive_payout(input int amt, input int ack_delay, input bit poke_start,
                              output int coins, output int dones);
    int         wait_cnt = 0;
    int         cyc = 0;
    int         rem_model = amt;
    bit         acked_last = 1'b0;
    logic [1:0] held = '0;
    logic [1:0] want;
    coins = 0;
    dones = 0;
    plan_payout(amt);
    @(negedge clk); start = 1'b1; change_in = CW'(amt);
    @(negedge clk); start = 1'b0; change_in = '0;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL busy_rise: got %b expected 1", busy); else n_pass++;
    while (cyc < 1000) begin
      if (done) dones++;
      if (acked_last) begin
        coin_ack = 1'b0;
        acked_last = 1'b0;
        n_checks++;
        if (coin_valid !== 1'b0) $display("FAIL valid_drop: got %b expected 0", coin_valid);
        else n_pass++;
        n_checks++;
        if (remaining !== CW'(rem_model))
          $display("FAIL remaining_step: got %0d expected %0d", remaining, rem_model);
        else n_pass++;
      end else if (coin_valid) begin
        if (wait_cnt == 0) held = coin_denom;
        else begin
          n_checks++;
          if (coin_denom !== held)
            $display("FAIL denom_stable: got %0d expected %0d", coin_denom, held);
          else n_pass++;
        end
        if (wait_cnt == ack_delay) begin
          n_checks++;
          if (exp_q.size() == 0) $display("FAIL unexpected_coin: got denom %0d expected none", coin_denom);
          else begin
            want = exp_q.pop_front();
            if (coin_denom !== want) $display("FAIL coin_denom: got %0d expected %0d", coin_denom, want);
            else n_pass++;
          end
          n_checks++;
          if (remaining !== CW'(rem_model))
            $display("FAIL remaining_before: got %0d expected %0d", remaining, rem_model);
          else n_pass++;
          rem_model -= value_of(coin_denom);
          model_stock[coin_denom]--;
          coins++;
          coin_ack = 1'b1;
          acked_last = 1'b1;
          wait_cnt = 0;
        end else wait_cnt++;
      end
      if (poke_start && cyc == 2) begin start = 1'b1; change_in = CW'(99); end
      else if (poke_start && cyc == 3) begin start = 1'b0; change_in = '0; end
      if (dones > 0 && !busy) break;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    coin_ack = 1'b0;
    n_checks++;
    if (cyc >= 1000) $display("FAIL payout_timeout: got %0d cycles expected under 1000", cyc);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL done_single: got done=%b busy=%b expected 0/0", done, busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (coin_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", coin_valid); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b expected 0", done); else n_pass++;
    n_checks++; if (fault !== 1'b0) $display("FAIL rst_fault: got %b expected 0", fault); else n_pass++;
    n_checks++; if (shortfall !== 1'b0) $display("FAIL rst_short: got %b expected 0", shortfall); else n_pass++;
    n_checks++; if (coin_denom !== 2'b00) $display("FAIL rst_denom: got %0d expected 0", coin_denom); else n_pass++;
    n_checks++; if (remaining !== '0) $display("FAIL rst_remaining: got %0d expected 0", remaining); else n_pass++;
    for (int d = 0; d < 4; d++) model_stock[d] = IS;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_greedy();
    int coins, dones;
    drive_payout(65, 0, 1'b1, coins, dones);
    n_checks++; if (coins !== exp_coins) $display("FAIL greedy_coins: got %0d expected %0d", coins, exp_coins); else n_pass++;
    n_checks++; if (dones !== 1) $display("FAIL greedy_done: got %0d expected 1", dones); else n_pass++;
    n_checks++; if (remaining !== CW'(exp_rem)) $display("FAIL greedy_rem: got %0d expected %0d", remaining, exp_rem); else n_pass++;
    n_checks++; if (shortfall !== (exp_rem > 0)) $display("FAIL greedy_short: got %b expected %b", shortfall, exp_rem > 0); else n_pass++;
    n_checks++; if (fault !== 1'b0) $display("FAIL greedy_fault: got %b expected 0", fault); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL greedy_left: got %0d expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_zero();
    bit saw_valid = 1'b0;
    @(negedge clk); start = 1'b1; change_in = '0;
    @(negedge clk); start = 1'b0;
    saw_valid |= coin_valid;
    n_checks++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL zero_n1: got busy=%b done=%b expected 1/0", busy, done); else n_pass++;
    @(negedge clk);
    saw_valid |= coin_valid;
    n_checks++; if (done !== 1'b1) $display("FAIL zero_done: got %b expected 1", done); else n_pass++;
    @(negedge clk);
    saw_valid |= coin_valid;
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL zero_end: got done=%b busy=%b expected 0/0", done, busy); else n_pass++;
    n_checks++; if (saw_valid) $display("FAIL zero_novalid: got 1 expected 0"); else n_pass++;
  endtask

  task automatic test_slow_ack();
    int coins, dones;
    drive_payout(7, 3, 1'b0, coins, dones);
    n_checks++; if (coins !== exp_coins) $display("FAIL slow_coins: got %0d expected %0d", coins, exp_coins); else n_pass++;
    n_checks++; if (dones !== 1) $display("FAIL slow_done: got %0d expected 1", dones); else n_pass++;
    n_checks++; if (remaining !== CW'(exp_rem)) $display("FAIL slow_rem: got %0d expected %0d", remaining, exp_rem); else n_pass++;
  endtask

  task automatic test_timeout();
    int cyc = 0;
    int vcnt = 0;
    int coins, dones;
    plan_payout(20);
    @(negedge clk); start = 1'b1; change_in = CW'(20);
    @(negedge clk); start = 1'b0; change_in = '0;
    while (!coin_valid && cyc < 10) begin @(negedge clk); cyc++; end
    while (coin_valid && vcnt < 100) begin @(negedge clk); vcnt++; end
    n_checks++; if (vcnt !== TO) $display("FAIL to_cycles: got %0d expected %0d", vcnt, TO); else n_pass++;
    n_checks++; if (fault !== 1'b1) $display("FAIL to_fault: got %b expected 1", fault); else n_pass++;
    n_checks++; if (remaining !== CW'(20)) $display("FAIL to_rem: got %0d expected 20", remaining); else n_pass++;
    n_checks++; if (done !== 1'b0 || busy !== 1'b1) $display("FAIL to_state: got done=%b busy=%b expected 0/1", done, busy); else n_pass++;
    @(negedge clk);
    n_checks++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL to_done: got done=%b busy=%b expected 1/0", done, busy); else n_pass++;
    coin_ack = 1'b1;
    @(negedge clk); coin_ack = 1'b0;
    @(negedge clk);
    n_checks++; if (remaining !== CW'(20) || fault !== 1'b1) $display("FAIL to_idle_ack: got rem=%0d fault=%b expected 20/1", remaining, fault); else n_pass++;
    drive_payout(1, 0, 1'b0, coins, dones);
    n_checks++; if (fault !== 1'b0) $display("FAIL to_clear: got %b expected 0", fault); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    int first_val;
    bit seen = 1'b0;
    plan_payout(30);
    first_val = value_of(exp_q[0]);
    @(negedge clk); start = 1'b1; change_in = CW'(30);
    @(negedge clk); start = 1'b0; change_in = '0;
    while (!coin_valid && cyc < 10) begin @(negedge clk); cyc++; end
    coin_ack = 1'b1;
    @(negedge clk); coin_ack = 1'b0;
    cyc = 0;
    while (!coin_valid && cyc < 10) begin @(negedge clk); cyc++; end
    n_checks++; if (coin_valid !== 1'b1 || remaining !== CW'(30 - first_val))
      $display("FAIL mid_second: got valid=%b rem=%0d expected 1/%0d", coin_valid, remaining, 30 - first_val);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || coin_valid !== 1'b0 || done !== 1'b0)
      $display("FAIL mid_ctrl: got busy=%b valid=%b done=%b expected 0/0/0", busy, coin_valid, done);
    else n_pass++;
    n_checks++; if (remaining !== '0 || coin_denom !== 2'b00 || fault !== 1'b0)
      $display("FAIL mid_data: got rem=%0d denom=%0d fault=%b expected 0/0/0", remaining, coin_denom, fault);
    else n_pass++;
    @(negedge clk); reset_n = 1'b1;
    for (int d = 0; d < 4; d++) model_stock[d] = IS;
    exp_q.delete();
    repeat (6) begin @(negedge clk); if (done || coin_valid || busy) seen = 1'b1; end
    n_checks++; if (seen) $display("FAIL mid_quiet: got activity expected none"); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int amts[3] = '{13, 4, 9};
    int coins, dones;
    for (int i = 0; i < 3; i++) begin
      drive_payout(amts[i], i, 1'b0, coins, dones);
      n_checks++; if (coins !== exp_coins || dones !== 1)
        $display("FAIL b2b_%0d: got coins=%0d dones=%0d expected %0d/1", amts[i], coins, dones, exp_coins);
      else n_pass++;
      n_checks++; if (remaining !== CW'(exp_rem))
        $display("FAIL b2b_rem_%0d: got %0d expected %0d", amts[i], remaining, exp_rem);
      else n_pass++;
    end
  endtask

`ifdef COIN_INVENTORY_EN
  task automatic test_inventory();
    int coins, dones;
    @(negedge clk); refill = 1'b1;
    @(negedge clk); refill = 1'b0;
    for (int d = 0; d < 4; d++) model_stock[d] = IS;
    drive_payout(38, 0, 1'b0, coins, dones);
    n_checks++; if (coins !== 8) $display("FAIL inv_coins: got %0d expected 8", coins); else n_pass++;
    n_checks++; if (remaining !== CW'(2)) $display("FAIL inv_rem: got %0d expected 2", remaining); else n_pass++;
    n_checks++; if (shortfall !== 1'b1) $display("FAIL inv_short: got %b expected 1", shortfall); else n_pass++;
    @(negedge clk); refill = 1'b1;
    @(negedge clk); refill = 1'b0;
    for (int d = 0; d < 4; d++) model_stock[d] = IS;
    drive_payout(3, 0, 1'b0, coins, dones);
    n_checks++; if (remaining !== '0 || shortfall !== 1'b0)
      $display("FAIL inv_refill: got rem=%0d short=%b expected 0/0", remaining, shortfall);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_greedy();
    test_zero();
    test_slow_ack();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
`ifdef COIN_INVENTORY_EN
    test_inventory();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
